// File: rtl/conv_enc_ctrl.sv
// -----------------------------------------------------------------------------
// conv_enc_ctrl
//
// Sequencing controller for a rate-1/3, K=7 tail-biting convolutional encoder.
// For each code block it pops one metadata byte (size flag + six tail bits),
// loads the tail into the encoder shift register, streams the block's data
// bytes LSB-first into the encoder one bit per cycle, and writes one coded
// symbol per input bit to the output FIFO with start/end-of-block markers.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   meta_empty      meta FIFO empty
//   blk_meta[7:0]   meta FIFO head (show-ahead): [7:2] tail, [1] unused, [0] size
//   blk_meta_rdreq  pop meta FIFO
//   data_empty      data FIFO empty
//   blk_data[7:0]   data FIFO head (show-ahead), bit 0 is the earliest bit
//   blk_data_rdreq  pop data FIFO
//   enc_init        load encoder state from enc_tail
//   enc_tail[5:0]   tail bits latched at the meta pop
//   enc_en          shift enc_bit into the encoder this cycle
//   enc_bit         current input bit
//   out_afull       output FIFO has fewer than two free entries
//   out_wrreq       write encoder output to the output FIFO
//   out_sop         with out_wrreq: first symbol of the block
//   out_eop         with out_wrreq: last symbol of the block
//   busy            a block is in progress
//   blk_done        one-cycle pulse alongside the final symbol write
// -----------------------------------------------------------------------------
module conv_enc_ctrl #(
    parameter int SMALL_BITS = 1056,
    parameter int LARGE_BITS = 6144,
    parameter int CNT_W      = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       meta_empty,
    input  logic [7:0] blk_meta,
    output logic       blk_meta_rdreq,
    input  logic       data_empty,
    input  logic [7:0] blk_data,
    output logic       blk_data_rdreq,
    output logic       enc_init,
    output logic [5:0] enc_tail,
    output logic       enc_en,
    output logic       enc_bit,
    input  logic       out_afull,
    output logic       out_wrreq,
    output logic       out_sop,
    output logic       out_eop,
    output logic       busy,
    output logic       blk_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic             size;
    logic [5:0]       tail;
    logic             sop_armed;

    // Encoder output registers delay the write by one cycle relative to enc_en.
    logic             wr_p1;
    logic             sop_p1;
    logic             eop_p1;

    logic             step;
    logic             last_bit;
    logic [CNT_W-1:0] last_cnt;
    logic             meta_pop;
    logic             init_now;
    logic             shift_now;

    // meta[1] carries no meaning for this block.
    logic             unused_meta_bit;
    assign unused_meta_bit = blk_meta[1];

    // The afull threshold already leaves room for the one write in flight,
    // so stepping only needs the current afull and data availability.
    assign step     = !data_empty && !out_afull;
    assign last_cnt = size ? CNT_W'(LARGE_BITS - 1) : CNT_W'(SMALL_BITS - 1);
    assign last_bit = (bit_cnt == last_cnt);

    always_comb begin
        state_nx  = state;
        meta_pop  = 1'b0;
        init_now  = 1'b0;
        shift_now = 1'b0;
        case (state)
            IDLE: begin
                if (!meta_empty) begin
                    meta_pop = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                init_now = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                if (step) begin
                    shift_now = 1'b1;
                    if (last_bit) begin
                        state_nx = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            size      <= 1'b0;
            tail      <= '0;
            sop_armed <= 1'b0;
            wr_p1     <= 1'b0;
            sop_p1    <= 1'b0;
            eop_p1    <= 1'b0;
        end else begin
            state  <= state_nx;
            wr_p1  <= shift_now;
            sop_p1 <= shift_now && sop_armed;
            eop_p1 <= shift_now && last_bit;

            if (meta_pop) begin
                size <= blk_meta[0];
                tail <= blk_meta[7:2];
            end

            if (init_now) begin
                bit_cnt   <= '0;
                bit_idx   <= '0;
                sop_armed <= 1'b1;
            end else if (shift_now) begin
                bit_cnt   <= bit_cnt + 1'b1;
                bit_idx   <= bit_idx + 1'b1;
                sop_armed <= 1'b0;
            end
        end
    end

    // All outputs are forced low while reset is held so nothing leaks out
    // during the reset cycle itself. Block length is a multiple of eight, so
    // the last bit always coincides with popping the final byte.
    assign blk_meta_rdreq = reset && meta_pop;
    assign enc_init       = reset && init_now;
    assign enc_tail       = {6{reset}} & tail;
    assign enc_en         = reset && shift_now;
    assign enc_bit        = reset && shift_now && blk_data[bit_idx];
    assign blk_data_rdreq = reset && shift_now && (bit_idx == 3'd7);
    assign out_wrreq      = reset && wr_p1;
    assign out_sop        = reset && sop_p1;
    assign out_eop        = reset && eop_p1;
    assign busy           = reset && (state != IDLE);
    assign blk_done       = reset && (state == FLUSH);

endmodule
